// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the seven-segment mux.
// The output word is registered and updates only when a conversion completes, or is cleared by reset.
module bin_to_bcd_seq #(
  parameter int N = 4,
  parameter int W = 14
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] bcd,
  output logic           overflow
);

  localparam int CW    = (W > 4*N) ? W : 4*N;
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [CW-1:0] pow10(input int n);
    logic [CW-1:0] p;
    p = CW'(1);
    for (int i = 0; i < n; i++) p = p * CW'(10);
    return p;
  endfunction

  localparam logic [CW-1:0] LIMIT = pow10(N);

  function automatic logic [4*N-1:0] add3(input logic [4*N-1:0] s);
    logic [4*N-1:0] r;
    r = s;
    for (int i = 0; i < N; i++)
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [4*N-1:0] sat_bcd(input logic ovf, input logic [4*N-1:0] s);
    return ovf ? {N{4'h9}} : s;
  endfunction

  state_t               state_q, state_d;
  logic [W-1:0]         sh_q, sh_d;
  logic [4*N-1:0]       scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [4*N-1:0]       bcd_q, bcd_d;
  logic                 overflow_q, overflow_d;
  logic [4*N-1:0]       adj;
  logic [CW-1:0]        bin_ext;

  assign bin_ext = CW'(bin);
  assign adj     = add3(scratch_q);

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sh_d      = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(W);
          ovf_d     = (bin_ext >= LIMIT);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Digits overflowing the top only happen for out-of-range inputs, which saturate anyway.
        scratch_d = {adj[4*N-2:0], sh_q[W-1]};
        sh_d      = {sh_q[W-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d      = sat_bcd(ovf_q, scratch_q);
        overflow_d = ovf_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized bench for bin_to_bcd_seq with a cycle-level behavioural reference model.
module tb_bin_to_bcd_seq;
  localparam int N = 4;
  localparam int W = 14;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [W-1:0]   bin;
  logic           busy, done, overflow;
  logic [4*N-1:0] bcd;

  bin_to_bcd_seq #(.N(N), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int             m_rem = 0;
  longint         m_pend = 0;
  logic           m_busy = 0, m_done = 0, m_ovf = 0;
  logic [4*N-1:0] m_bcd = '0;
  int             accepts = 0, aborts = 0, dones = 0;
  logic           rst_edge;
  logic [4*N-1:0] prev_bcd = '0;

  function automatic longint limit();
    longint l = 1;
    for (int i = 0; i < N; i++) l = l * 10;
    return l;
  endfunction

  function automatic logic [4*N-1:0] to_bcd(input longint v);
    logic [4*N-1:0] r;
    longint x;
    r = '0;
    if (v >= limit()) return {N{4'h9}};
    x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      if (m_rem != 0) aborts++;
      m_rem = 0; m_busy = 0; m_done = 0; m_bcd = '0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_rem == 0) begin
        if (start) begin
          m_pend = longint'(bin);
          m_rem  = W + 1;
          m_busy = 1;
          accepts++;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_bcd  = to_bcd(m_pend);
          m_ovf  = (m_pend >= limit());
          m_done = 1;
          m_busy = 0;
        end
      end
    end
    rst_edge = !reset_n;
    @(negedge clk);
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("bcd", 64'(bcd), 64'(m_bcd));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (!rst_edge && done !== 1'b1) chk("bcd_stable", 64'(bcd), 64'(prev_bcd));
    prev_bcd = bcd;
    if (done === 1'b1) dones++;
  endtask

  // Single-pulse conversion with hand-computed expectations; assumes DUT is idle.
  task automatic convert(input int v, input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat;
    bin = W'(v); start = 1'b1;
    tick();
    start = 1'b0; bin = W'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk($sformatf("latency_%0d", v), 64'(lat), 64'd15);
    chk($sformatf("lit_bcd_%0d", v), 64'(bcd), 64'(exp_bcd));
    chk($sformatf("lit_ovf_%0d", v), 64'(overflow), 64'(exp_ovf));
  endtask

  int q[$];
  int idx;
  int d0, a0, ab0, budget;

  initial begin
    reset_n = 1'b0; start = 1'b0; bin = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    tick();

    convert(1234, 16'h1234, 1'b0);
    convert(0, 16'h0000, 1'b0);
    convert(9999, 16'h9999, 1'b0);
    convert(10000, 16'h9999, 1'b1);
    convert(16383, 16'h9999, 1'b1);
    convert(7, 16'h0007, 1'b0);

    // Start held high with bin changing every cycle
    d0 = dones;
    start = 1'b1; bin = W'(100);
    for (int i = 0; i < 80; i++) begin
      tick();
      bin = bin + W'(1);
    end
    start = 1'b0;
    chk("held_start_dones", 64'(dones - d0), 64'd5);

    // Reset in the middle of a conversion
    d0 = dones;
    bin = W'(500); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_bcd", 64'(bcd), 64'd0);
    repeat (20) tick();
    chk("abort_no_done", 64'(dones - d0), 64'd0);
    convert(321, 16'h0321, 1'b0);

    // Sweep plus random values with random start noise while busy
    for (int v = 0; v < 100; v++) q.push_back(v);
    for (int v = 9900; v <= 10050; v++) q.push_back(v);
    for (int v = 16380; v <= 16383; v++) q.push_back(v);
    for (int i = 0; i < 200; i++) q.push_back(int'($urandom_range(0, 16383)));
    d0 = dones; a0 = accepts; ab0 = aborts;
    idx = 0; budget = 0;
    while (idx < q.size() && budget < 20000) begin
      if (m_rem == 0) begin
        bin = W'(q[idx]); idx++; start = 1'b1;
      end else begin
        start = 1'($urandom_range(0, 1)); bin = W'($urandom);
      end
      tick();
      budget++;
    end
    start = 1'b0;
    repeat (20) tick();
    chk("sweep_complete", 64'(idx), 64'(q.size()));
    chk("sweep_done_count", 64'(dones - d0), 64'((accepts - a0) - (aborts - ab0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
